mul_wallacetree_pipe: RTL and testbench



---
 rtl/mul_wt_pkg.sv | 45 ++++
 rtl/mul_wallacetree_pipe_reduce.sv | 75 +++++++
 rtl/mul_wallacetree_pipe.sv | 102 ++++++++++
 tb/tb_mul_wallacetree_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_wt_pkg.sv
// mul_wt_pkg: shared widths, carry-save and stage types, Wallace level helpers
// Types are sized for the widest legal build (MAX_WIDTH operands,
// MAX_TAG_W tags). Narrower instances zero-extend into them, and synthesis
// trims the constant-zero bits.
package mul_wt_pkg;

    localparam int DEFAULT_WIDTH  = 11;
    localparam int DEFAULT_STAGES = 2;
    localparam int MAX_WIDTH      = 32;
    localparam int MAX_TAG_W      = 16;

    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] sum;
        logic [2*MAX_WIDTH-1:0] carry;
    } csa_pair_t;

    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] payload;
        logic [MAX_TAG_W-1:0]   tag;
        logic                   sgn;
    } stage_t;

    // Rows left after one Wallace level: each group of three becomes two,
    // and a leftover pair or single row is carried forward.
    function automatic int wt_next(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int wt_rows(input int n, input int l);
        int r = n;
        for (int k = 0; k < l; k++) r = wt_next(r);
        return r;
    endfunction

    function automatic int wt_levels(input int n);
        int r = n;
        int l = 0;
        while (r > 2) begin
            r = wt_next(r);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mul_wallacetree_pipe_reduce.sv
// wallace_reduce: combinational partial-product generation and Wallace reduction to a carry-save pair
// Ports:
//   a, b : WIDTH-bit operands
//   sgn  : treat operands as two's complement (only with MUL_WALLACETREE_SIGNED_EN)
//   csa  : sum and carry rows; their sum mod 2^(2*WIDTH) is the exact product
// With MUL_WALLACETREE_SIGNED_EN, Baugh-Wooley correction is applied when sgn=1.
// Without the macro, the array is plain unsigned.
module wallace_reduce
    import mul_wt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MUL_WALLACETREE_SIGNED_EN
    input  logic             sgn,
`endif
    output csa_pair_t        csa
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = 2 * MAX_WIDTH;
`ifdef MUL_WALLACETREE_SIGNED_EN
    localparam int NR = WIDTH + 1;
`else
    localparam int NR = WIDTH;
`endif
    localparam int NL = wt_levels(NR);

    logic [PW-1:0] rows [0:NL][0:NR-1];

    for (genvar j = 0; j < WIDTH; j++) begin : g_pp
        logic [WIDTH-1:0] pp;
`ifdef MUL_WALLACETREE_SIGNED_EN
        // Partial products pairing exactly one sign bit are inverted.
        always_comb
            for (int i = 0; i < WIDTH; i++)
                pp[i] = (a[i] & b[j]) ^ (sgn & ((i == WIDTH - 1) != (j == WIDTH - 1)));
`else
        assign pp = a & {WIDTH{b[j]}};
`endif
        assign rows[0][j] = PW'(pp) << j;
    end

`ifdef MUL_WALLACETREE_SIGNED_EN
    // Baugh-Wooley constants: ones at bit WIDTH and at bit 2*WIDTH-1.
    assign rows[0][WIDTH] = sgn ? (PW'(1) << WIDTH) | (PW'(1) << (PW - 1)) : '0;
`endif

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int N = wt_rows(NR, l);
        localparam int G = N / 3;
        for (genvar g = 0; g < G; g++) begin : g_fa
            logic [PW-1:0] x, y, z;
            assign x = rows[l][3*g];
            assign y = rows[l][3*g+1];
            assign z = rows[l][3*g+2];
            assign rows[l+1][2*g]   = x ^ y ^ z;
            assign rows[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
        if (N % 3 == 2) begin : g_ha
            assign rows[l+1][2*G]   = rows[l][3*G] ^ rows[l][3*G+1];
            assign rows[l+1][2*G+1] = (rows[l][3*G] & rows[l][3*G+1]) << 1;
        end else if (N % 3 == 1) begin : g_pass
            assign rows[l+1][2*G] = rows[l][3*G];
        end
        for (genvar r = wt_next(N); r < NR; r++) begin : g_zero
            assign rows[l+1][r] = '0;
        end
    end

    assign csa.sum   = CW'(rows[NL][0]);
    assign csa.carry = CW'(rows[NL][1]);

endmodule

// File: rtl/mul_wallacetree_pipe.sv
// mul_wallacetree_pipe: pipelined WIDTH x WIDTH Wallace-tree multiplier with tag sideband and valid/ready
// Ports:
//   clk, rst (async, active-high), flush (sync clear of all stages)
//   in_valid/in_ready, in_a, in_b, in_tag   : operand side
//   in_signed                               : two's complement operands (MUL_WALLACETREE_SIGNED_EN only)
//   out_valid/out_ready, out_result, out_tag: product side
// Stage 1 holds the carry-save pair, stage 2 the resolved product, and
// stages 3..STAGES are plain delay registers. STAGES must be at least 2,
// and TAG_W must not exceed MAX_TAG_W.
module mul_wallacetree_pipe
    import mul_wt_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef MUL_WALLACETREE_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    logic [STAGES:1] v, ld, dr;
    csa_pair_t       csa, s1_csa;
    logic [TAG_W-1:0] s1_tag;
    logic            s1_sgn;
    stage_t          st [2:STAGES];
    logic            unused_bits;

    wallace_reduce #(.WIDTH(WIDTH)) u_tree (
        .a   (in_a),
        .b   (in_b),
`ifdef MUL_WALLACETREE_SIGNED_EN
        .sgn (in_signed),
`endif
        .csa (csa)
    );

    // Stall chain from the output back to the input: a stage drains when
    // its successor loads, and the last stage drains on the output handshake.
    always_comb begin
        ld = '0;
        dr = '0;
        dr[STAGES] = out_ready;
        for (int k = STAGES; k >= 2; k--) begin
            ld[k] = v[k-1] && (!v[k] || dr[k]);
            dr[k-1] = ld[k];
        end
        in_ready = !rst && !flush && (!v[1] || dr[1]);
        ld[1] = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v      <= '0;
            s1_csa <= '0;
            s1_tag <= '0;
            s1_sgn <= 1'b0;
            for (int k = 2; k <= STAGES; k++) st[k] <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++)
                if (ld[k]) v[k] <= 1'b1;
                else if (dr[k]) v[k] <= 1'b0;
            if (ld[1]) begin
                s1_csa <= csa;
                s1_tag <= in_tag;
`ifdef MUL_WALLACETREE_SIGNED_EN
                s1_sgn <= in_signed;
`else
                s1_sgn <= 1'b0;
`endif
            end
            if (ld[2])
                st[2] <= '{payload: s1_csa.sum + s1_csa.carry,
                           tag:     MAX_TAG_W'(s1_tag),
                           sgn:     s1_sgn};
            for (int k = 3; k <= STAGES; k++)
                if (ld[k]) st[k] <= st[k-1];
        end
    end

    assign out_valid  = v[STAGES];
    assign out_result = st[STAGES].payload[2*WIDTH-1:0];
    assign out_tag    = st[STAGES].tag[TAG_W-1:0];

    // Bits above the configured widths are always zero or modulo overflow.
    assign unused_bits = ^{st[STAGES].payload >> (2 * WIDTH), st[STAGES].tag >> TAG_W, st[STAGES].sgn};

endmodule

// File: tb/tb_mul_wallacetree_pipe.sv
// tb_mul_wallacetree_pipe: randomized self-checking bench with a scoreboard of plain-arithmetic products
module tb_mul_wallacetree_pipe #(
    parameter int W = 11,
    parameter int S = 2,
    parameter int T = 4
);

    logic           clk = 1'b0;
    logic           rst, flush, in_valid, in_ready, out_valid, out_ready, in_signed;
    logic [W-1:0]   in_a, in_b;
    logic [T-1:0]   in_tag, out_tag;
    logic [2*W-1:0] out_result;

    logic [63:0] exp_res [$];
    logic [15:0] exp_tag [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mask;
    int          w, stalls, lat;
    bit          done;

    always #5 clk = ~clk;

    mul_wallacetree_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
`ifdef MUL_WALLACETREE_SIGNED_EN
        .in_signed  (in_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint x, y;
        logic [63:0] p;
        x = longint'(a);
        y = longint'(b);
        if (s && a[W-1]) x -= longint'(1) << W;
        if (s && b[W-1]) y -= longint'(1) << W;
        p = x * y;
        return p & ((64'd1 << (2 * W)) - 64'd1);
    endfunction

    // Scoreboard: record accepted operands, retire on output handshakes.
    always @(negedge clk) begin
        if (rst) begin
            exp_res.delete();
            exp_tag.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_res.size() == 0) check("spurious_out", exp_res.size(), 1);
                else begin
                    check("result", out_result, exp_res.pop_front());
                    check("tag", out_tag, exp_tag.pop_front());
                end
            end
            if (flush) begin
                exp_res.delete();
                exp_tag.delete();
            end else if (in_valid && in_ready) begin
                exp_res.push_back(ref_mul(32'(in_a), 32'(in_b), in_signed));
                exp_tag.push_back(16'(in_tag));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [15:0] t, output int waits);
        bit ok;
        in_valid = 1'b1;
        in_a = a[W-1:0];
        in_b = b[W-1:0];
        in_tag = t[T-1:0];
        waits = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!ok && waits < 200);
        if (!ok) check("send_timeout", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        out_ready = 1'b1;
        while (exp_res.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain_empty", exp_res.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        mask = (W == 32) ? 32'hFFFF_FFFF : (32'd1 << W) - 32'd1;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single transaction and its latency.
        send(32'h575, 32'h6BA, 16'd3, w);
        lat = 1;
        while (lat < 4 * S) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, S);
        drain();

        // Back-to-back stream: no input stall allowed with out_ready high.
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            send($urandom & mask, $urandom & mask, 16'(i), w);
            stalls += w - 1;
        end
        check("stream_stalls", stalls, 0);
        drain();

        // Random downstream backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send($urandom & mask, $urandom & mask, 16'($urandom), w);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Deterministic stall: output holds, input backs up once full.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send($urandom & mask, $urandom & mask, 16'(i + 8), w);
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    #2;
                    check("bp_in_ready", in_ready, exp_res.size() < S);
                    check("bp_out_valid", out_valid, exp_res.size() >= S);
                    if (out_valid && exp_res.size() != 0) begin
                        check("bp_hold_result", out_result, exp_res[0]);
                        check("bp_hold_tag", out_tag, exp_tag[0]);
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Extremes.
        send(mask, mask, 16'd1, w);
        send(32'd0, mask, 16'd2, w);
        send(32'd1, 32'd1, 16'd3, w);
        send(mask, 32'd0, 16'd4, w);
        send(mask, 32'd1, 16'd5, w);
        drain();

        // Flush with two in flight and a competing input.
        out_ready = 1'b0;
        send($urandom & mask, $urandom & mask, 16'd6, w);
        send($urandom & mask, $urandom & mask, 16'd7, w);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2 * S + 2; c++) begin
            @(negedge clk);
            check("flush_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset during a stall.
        out_ready = 1'b0;
        send($urandom & mask, $urandom & mask, 16'd9, w);
        send($urandom & mask, $urandom & mask, 16'd10, w);
        repeat (S) @(posedge clk);
        #2;
        check("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_result", out_result, 0);
        check("rst_async_tag", out_tag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2 * S; c++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;

`ifdef MUL_WALLACETREE_SIGNED_EN
        in_signed = 1'b1;
        send(mask, mask, 16'd1, w);
        send(32'd1 << (W - 1), 32'd1, 16'd2, w);
        send(32'd1 << (W - 1), 32'd1 << (W - 1), 16'd3, w);
        for (int i = 0; i < 40; i++) begin
            in_signed = 1'($urandom_range(0, 1));
            send($urandom & mask, $urandom & mask, 16'(i), w);
        end
        in_signed = 1'b0;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
